// File: rtl/serial_rx.sv
// serial_rx: receive side of the calculator's 32-bit serial link.
// Samples data_enable/sdi on posedge sclk and shifts each frame in MSB-first.
// A frame is one preamble copy of the MSB followed by WIDTH payload bits.
// Received words are held in a one-word buffer behind a valid/ready handshake.
// Overrun and framing errors are reported as one-cycle pulses.
// Optional build macro: SERIAL_RX_PREAMBLE_CHECK_EN. When it is defined, the
// preamble must match the payload MSB, or the frame is a framing error.
module serial_rx #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FRAME_BITS = 33,
    parameter int unsigned CNT_W      = 7
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             data_enable,
    input  logic             sdi,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             rx_busy,
    output logic             overrun,
    output logic             frame_error
);

    localparam logic [CNT_W-1:0] FRAME_BITS_C = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX_C    = '1;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        RECV
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overrun_q;
    logic             ferr_q;
    logic             frame_good;

`ifdef SERIAL_RX_PREAMBLE_CHECK_EN
    logic             pre_q;

    // Good frame: exact sample count and preamble equal to the payload MSB.
    always_comb begin
        frame_good = (cnt_q == FRAME_BITS_C) && (pre_q == shift_q[WIDTH-1]);
    end
`else
    // Good frame: exact sample count only.
    always_comb begin
        frame_good = (cnt_q == FRAME_BITS_C);
    end
`endif

    // Receive FSM, shift register, counter, output buffer and error pulses.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARM;
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef SERIAL_RX_PREAMBLE_CHECK_EN
            pre_q     <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;

            // Consumption; a frame-end load below overrides this on the same edge.
            if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                // Wait out any frame that was already running at reset release.
                ARM: begin
                    if (!data_enable) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (data_enable) begin
                        shift_q <= {{(WIDTH-1){1'b0}}, sdi};
                        cnt_q   <= CNT_W'(1);
`ifdef SERIAL_RX_PREAMBLE_CHECK_EN
                        pre_q   <= sdi;
`endif
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (data_enable) begin
                        shift_q <= {shift_q[WIDTH-2:0], sdi};
                        // Saturate so very long frames never wrap into a false match.
                        if (cnt_q != CNT_MAX_C) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_q <= IDLE;
                        if (frame_good) begin
                            if (!valid_q || data_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ARM;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign overrun     = overrun_q;
    assign frame_error = ferr_q;
    assign rx_busy     = (state_q == RECV);

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: a table of frames with expected buffer state,
// plus hand-written reset-mid-frame and back-to-back sequences.
module tb_serial_rx;

    logic        sclk;
    logic        rst_n;
    logic        data_enable;
    logic        sdi;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        rx_busy;
    logic        overrun;
    logic        frame_error;

    int tests_run;
    int tests_failed;

    serial_rx #(
        .WIDTH     (32),
        .FRAME_BITS(33),
        .CNT_W     (7)
    ) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .data_enable(data_enable),
        .sdi        (sdi),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .rx_busy    (rx_busy),
        .overrun    (overrun),
        .frame_error(frame_error)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic        pre;       // preamble sample
        logic [31:0] word;      // payload, MSB first
        int          len;       // samples with enable high
        logic        rdy_end;   // data_ready on the frame-end edge
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ovr;
        logic        exp_ferr;
        logic        rdy_post;  // data_ready on the following edge
        logic        exp_valid_post;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply current inputs across one posedge, then settle past it.
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Sample k of a frame: preamble, then word[31..0], then zeros.
    function automatic logic frame_bit(input logic pre, input logic [31:0] word, input int k);
        if (k == 0) return pre;
        if (k <= 32) return word[32-k];
        return 1'b0;
    endfunction

    // Drive len enable-high samples with data_ready low; ends just before the frame-end edge.
    task automatic drive_frame(input logic pre, input logic [31:0] word, input int len);
        data_ready = 1'b0;
        for (int k = 0; k < len; k++) begin
            data_enable = 1'b1;
            sdi = frame_bit(pre, word, k);
            step();
            if (k == 0) chk("rx_busy_start", 32'(rx_busy), 32'd1);
        end
        data_enable = 1'b0;
        sdi = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        data_enable  = 1'b0;
        sdi          = 1'b0;
        data_ready   = 1'b0;

        //           pre   word          len  rdyE  v     data          ovr   ferr  rdyP  vP
        vecs[0] = '{1'b1, 32'hDEADBEEF,  33, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h00000001,  33, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h80000000,  33, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h12345678,  33, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'hCAFEF00D,  33, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF,  20, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'hA5A5A5A5,  33, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0};
        // 161 samples: an unsaturated 7-bit counter would wrap to 33 here.
        vecs[7] = '{1'b0, 32'h00000000, 161, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef SERIAL_RX_PREAMBLE_CHECK_EN
        vecs[8] = '{1'b0, 32'hFFFFFFFF,  33, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        vecs[8] = '{1'b0, 32'hFFFFFFFF,  33, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

        // Reset state
        #12;
        chk("rst_data_out",    data_out,           32'h0);
        chk("rst_data_valid",  32'(data_valid),    32'd0);
        chk("rst_rx_busy",     32'(rx_busy),       32'd0);
        chk("rst_overrun",     32'(overrun),       32'd0);
        chk("rst_frame_error", 32'(frame_error),   32'd0);
        @(negedge sclk);
        rst_n = 1'b1;
        step();
        step();

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            drive_frame(vecs[i].pre, vecs[i].word, vecs[i].len);
            data_ready = vecs[i].rdy_end;
            step();
            chk($sformatf("v%0d_valid", i), 32'(data_valid),  32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_data",  i), data_out,         vecs[i].exp_data);
            chk($sformatf("v%0d_ovr",   i), 32'(overrun),     32'(vecs[i].exp_ovr));
            chk($sformatf("v%0d_ferr",  i), 32'(frame_error), 32'(vecs[i].exp_ferr));
            chk($sformatf("v%0d_busy",  i), 32'(rx_busy),     32'd0);
            data_ready = vecs[i].rdy_post;
            step();
            chk($sformatf("v%0d_valid_post", i), 32'(data_valid), 32'(vecs[i].exp_valid_post));
            chk($sformatf("v%0d_ovr_post",   i), 32'(overrun),     32'd0);
            chk($sformatf("v%0d_ferr_post",  i), 32'(frame_error), 32'd0);
            data_ready = 1'b0;
        end

        // Load a word so the reset must visibly clear the buffer.
        drive_frame(1'b0, 32'h11112222, 33);
        step();
        chk("pre_rst_valid", 32'(data_valid), 32'd1);

        // Reset asserted at bit 10 of a frame, enable stays high.
        drive_frame(1'b1, 32'h87654321, 10);
        data_enable = 1'b1;
        sdi = frame_bit(1'b1, 32'h87654321, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_data",  data_out,        32'h0);
        chk("midrst_busy",  32'(rx_busy),    32'd0);
        @(negedge sclk);
        rst_n = 1'b1;
        for (int k = 11; k < 33; k++) begin
            sdi = frame_bit(1'b1, 32'h87654321, k);
            step();
            chk("armed_busy", 32'(rx_busy), 32'd0);
        end
        data_enable = 1'b0;
        sdi = 1'b0;
        step();
        chk("armed_end_valid", 32'(data_valid),  32'd0);
        chk("armed_end_ferr",  32'(frame_error), 32'd0);

        // Next frame follows with the minimum one-cycle gap.
        drive_frame(1'b0, 32'h0F0F0F0F, 33);
        step();
        chk("after_rst_valid", 32'(data_valid),  32'd1);
        chk("after_rst_data",  data_out,         32'h0F0F0F0F);
        chk("after_rst_ferr",  32'(frame_error), 32'd0);

        // Back-to-back: next frame starts on the edge right after frame end, consumer reads meanwhile.
        data_ready = 1'b1;
        data_enable = 1'b1;
        sdi = 1'b0;
        step();
        chk("b2b_consumed", 32'(data_valid), 32'd0);
        chk("b2b_busy",     32'(rx_busy),    32'd1);
        data_ready = 1'b0;
        for (int k = 1; k < 33; k++) begin
            sdi = frame_bit(1'b0, 32'h3C3C00FF, k);
            step();
        end
        data_enable = 1'b0;
        sdi = 1'b0;
        step();
        chk("b2b_valid", 32'(data_valid), 32'd1);
        chk("b2b_data",  data_out,        32'h3C3C00FF);

        // data_out holds while valid and unconsumed.
        step();
        step();
        chk("hold_data",  data_out,        32'h3C3C00FF);
        chk("hold_valid", 32'(data_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receive-side counterpart to the calculator's 32-bit serial transmitter.
- Consumes the transmitter's chip-select (data_enable) and serial data (sdo), both clocked by sclk.
- Deserialises each frame MSB-first into a parallel word.
- Presents the word to the display/result logic over a valid/ready handshake, with a one-word holding buffer plus overrun and framing-error reporting.

Parameters:
- WIDTH, 32: payload word width in bits.
- FRAME_BITS, 33: exact number of samples per frame: one MSB preamble copy plus WIDTH payload bits.
- CNT_W, 7: bit-counter width; saturates at 2^CNT_W-1.

Ports:
- sclk, input, 1: serial clock. All logic on posedge; the transmitter drives on negedge, so sampling is mid-bit.
- rst_n, input, 1: reset, asynchronous, active-low.
- data_enable, input, 1: frame enable / chip select from the transmitter.
- sdi, input, 1: serial data in, MSB first.
- data_out, output, WIDTH: received word; held stable while data_valid=1.
- data_valid, output, 1: data_out holds an unconsumed word.
- data_ready, input, 1: consumer accepts the word on a posedge where data_valid && data_ready.
- rx_busy, output, 1: a frame is in progress (state RECV).
- overrun, output, 1: one-cycle pulse; a good frame arrived while the buffer was full, and the new word was dropped.
- frame_error, output, 1: one-cycle pulse; a frame ended with a sample count other than FRAME_BITS.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ARM; data_out=0, data_valid=0, rx_busy=0, overrun=0, frame_error=0.
  - Shift register and counter cleared.
- States:
  - ARM: wait for data_enable=0, then go to IDLE. A frame already in flight at reset release is ignored entirely: no valid, no error.
  - IDLE: on data_enable=1, sample sdi into shift[0], set count=1, go to RECV.
  - RECV, while data_enable=1: shift <= {shift[WIDTH-2:0], sdi}; count++, saturating. The shift register always holds the last WIDTH samples.
  - RECV, first posedge with data_enable=0 (the frame-end edge): go to IDLE and evaluate the frame.
    - count==FRAME_BITS: good frame.
    - Otherwise: frame_error=1 for one cycle; word discarded.
- Good-frame handling on the frame-end edge:
  - Buffer free (data_valid=0), or being consumed this same edge (data_valid && data_ready): data_out <= shift, data_valid <= 1.
  - Buffer full and data_ready=0: overrun=1 for one cycle; data_out and data_valid unchanged.
- Latency: data_valid rises on the frame-end edge, i.e. the first posedge that samples data_enable=0.
- Handshake:
  - data_valid falls on the posedge where data_ready=1, unless a new good frame is loaded on the same edge, in which case it stays 1 with the new word.
  - data_ready while data_valid=0 is ignored.
- Back-to-back frames: IDLE may accept data_enable=1 on the edge immediately after the frame-end edge. A minimum one-cycle enable-low gap is required and is satisfied by the transmitter.
- Counter saturation: frames longer than 2^CNT_W-1 still flag frame_error. They never wrap around to a false match.
- rx_busy=1 exactly when state==RECV.

Optional Feature:
- Macro SERIAL_RX_PREAMBLE_CHECK_EN.
- Defined: the first sample of the frame (the preamble) is captured. A frame with count==FRAME_BITS whose preamble differs from bit WIDTH-1 of the final shift contents is treated as a framing error: frame_error pulses, no load, no overrun.
- Undefined: the preamble is not stored or checked; only the count check applies.

Test Plan:
- Frame 0xDEADBEEF (enable high 33 cycles: preamble 1, then bits 31..0) with data_ready=1 -> data_out=0xDEADBEEF and data_valid=1 on the frame-end edge, low on the next edge; no error pulses.
- Frame 0x00000001, data_ready=0, then frame 0x80000000 -> data_out stays 0x00000001, data_valid stays 1, overrun pulses once at the 2nd frame-end edge. Then data_ready=1 for one cycle -> data_valid=0.
- data_valid=1 holding 0x12345678, data_ready=1 exactly on the frame-end edge of frame 0xCAFEF00D -> data_out=0xCAFEF00D, data_valid stays 1, no overrun.
- Enable high for 20 cycles -> frame_error one-cycle pulse, data_valid stays 0. A following correct 33-cycle frame 0xA5A5A5A5 is received normally.
- rst_n pulsed low at bit 10 of a frame, enable remaining high -> no valid and no frame_error for that frame. The next full frame 0x0F0F0F0F is received.
- With SERIAL_RX_PREAMBLE_CHECK_EN: 33-cycle frame with preamble 0 and payload 0xFFFFFFFF -> frame_error pulse, no valid. Without the macro, the same stimulus -> data_out=0xFFFFFFFF, data_valid=1.
